// File: rtl/nf10_barrier_pkg.sv
// Shared constants for the simulation-barrier client: FSM state codes and
// default timing parameters also used by the barrier bench.
package nf10_barrier_pkg;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_REQ     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int unsigned DEF_IDLE_HOLD = 4;
  localparam int unsigned DEF_TIMEOUT   = 65535;
  localparam int unsigned DEF_CNT_WIDTH = 16;

  // Every state other than RUN keeps the stimulus source from starting a packet.
  function automatic logic st_holds(input logic [1:0] st);
    return st != ST_RUN;
  endfunction

endpackage

// File: rtl/nf10_barrier_activity_mon.sv
// Passive AXI4-Stream tap: tracks whether a packet is open and stretches
// activity for IDLE_HOLD cycles after the last accepted beat.
module nf10_barrier_activity_mon
  import nf10_barrier_pkg::*;
#(
  parameter int unsigned IDLE_HOLD = DEF_IDLE_HOLD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tvalid_i,
  input  logic tready_i,
  input  logic tlast_i,
  output logic beat_o,
  output logic in_pkt_o,
  output logic activity_o
);

  localparam int unsigned IW = (IDLE_HOLD < 1) ? 1 : $clog2(IDLE_HOLD + 1);
  localparam logic [IW-1:0] HOLD_C = IW'(IDLE_HOLD);

  logic          in_pkt_q, in_pkt_d;
  logic [IW-1:0] idle_q, idle_d;

  assign beat_o = tvalid_i & tready_i;

  always_comb begin
    in_pkt_d = in_pkt_q;
    idle_d   = idle_q;
    if (beat_o) begin
      in_pkt_d = ~tlast_i;
      idle_d   = '0;
    end else if (idle_q != HOLD_C) begin
      idle_d = idle_q + 1'b1;
    end
  end

  // idle_q starts saturated so a freshly reset port reports no activity.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_pkt_q <= 1'b0;
      idle_q   <= HOLD_C;
    end else begin
      in_pkt_q <= in_pkt_d;
      idle_q   <= idle_d;
    end
  end

  assign in_pkt_o   = in_pkt_q;
  assign activity_o = in_pkt_q | (idle_q < HOLD_C);

endmodule

// File: rtl/nf10_barrier_client.sv
// Per-port barrier agent: on a sequencer command it holds new traffic, drains
// the open packet, requests the barrier and waits for proceed before resuming.
module nf10_barrier_client
  import nf10_barrier_pkg::*;
#(
  parameter int unsigned IDLE_HOLD = DEF_IDLE_HOLD,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 axi_aclk,
  input  logic                 axi_resetn,
  input  logic                 s_tvalid,
  input  logic                 s_tready,
  input  logic                 s_tlast,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  output logic                 traffic_hold,
  output logic                 activity,
  output logic                 barrier_req,
  input  logic                 barrier_proceed,
  output logic                 barrier_done,
  output logic [CNT_WIDTH-1:0] barrier_count,
  output logic                 err_timeout
);

  // TIMEOUT must be representable in CNT_WIDTH bits.
  localparam logic [CNT_WIDTH-1:0] TMO_C = CNT_WIDTH'(TIMEOUT);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 beat, in_pkt, act;

  nf10_barrier_activity_mon #(
    .IDLE_HOLD (IDLE_HOLD)
  ) u_mon (
    .clk_i      (axi_aclk),
    .rst_ni     (axi_resetn),
    .tvalid_i   (s_tvalid),
    .tready_i   (s_tready),
    .tlast_i    (s_tlast),
    .beat_o     (beat),
    .in_pkt_o   (in_pkt),
    .activity_o (act)
  );

  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cmd_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A beat this cycle (even a tlast one) means the port is not quiet yet.
        if (!in_pkt && !beat) state_d = ST_REQ;
      end
      ST_REQ: begin
        // Counts completed REQ cycles; err latches on the edge reaching TIMEOUT.
        tmo_d = (tmo_q == TMO_C) ? tmo_q : tmo_q + 1'b1;
        if (tmo_d == TMO_C) err_d = 1'b1;
        if (barrier_proceed) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!barrier_proceed) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= ST_RUN;
      tmo_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready     = (state_q == ST_RUN);
  assign traffic_hold  = st_holds(state_q);
  assign barrier_req   = (state_q == ST_REQ);
  assign activity      = act;
  assign barrier_done  = done_q;
  assign barrier_count = cnt_q;
  assign err_timeout   = err_q;

endmodule
